sync_conditioner: RTL and testbench

//  Parametrised NUM_CH-channel sync front end; replaces per-signal polarity/presence detection.
//  Per channel: synchronise input, measure high/low time per period, lock polarity with hysteresis.

---
 rtl/sync_cond_pkg.sv | 17 +
 rtl/sync_channel.sv | 149 ++++++++++++++
 rtl/sync_conditioner.sv | 46 ++++
 tb/tb_sync_conditioner.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sync_cond_pkg.sv
// Shared definitions for the sync conditioner.
//   state_t  : per-channel detection state (LOST / ACQUIRE / LOCKED)
//   MODE_*   : per-channel output mode codes presented on the mode port
package sync_cond_pkg;

  typedef enum logic [1:0] {
    ST_LOST    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_AUTO  = 2'b00;  // normalise using locked polarity
  localparam logic [1:0] MODE_NEG   = 2'b01;  // treat input as active low
  localparam logic [1:0] MODE_POS   = 2'b10;  // treat input as active high
  localparam logic [1:0] MODE_BLANK = 2'b11;  // hold output inactive

endpackage

// File: rtl/sync_channel.sv
// One sync channel: 2-flop synchroniser, edge detect, high/low period
// measurement, loss timeout, polarity lock with hysteresis and the
// registered active-low output mux.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   sync_in     : raw asynchronous sync input, either polarity
//   mode        : output mode (MODE_AUTO/NEG/POS/BLANK)
//   sync_out_x  : registered normalised sync, active low
//   polarity    : locked polarity, 1 = positive-going pulses
//   present     : channel is not LOST
//   locked      : polarity is locked
module sync_channel
  import sync_cond_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 65000,
  parameter int LOCK_CNT    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sync_in,
  input  logic [1:0] mode,
  output logic       sync_out_x,
  output logic       polarity,
  output logic       present,
  output logic       locked
);

  localparam int                 AGREE_W   = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
  // The counter reaches TIMEOUT_CYC-1 on the clock after it holds TIMEOUT_CYC-2.
  localparam logic [CNT_W-1:0]   TO_FIRE   = CNT_W'(TIMEOUT_CYC - 2);
  localparam logic [AGREE_W-1:0] AGREE_MAX = AGREE_W'(LOCK_CNT);

  logic [1:0]         sync_ff;
  logic               s, s_d, rise, any_edge;
  logic [CNT_W-1:0]   hi_cnt, lo_cnt, to_cnt;
  state_t             state, state_next;
  logic               cand, cand_next;
  logic [AGREE_W-1:0] agree, agree_next;
  logic               pol, pol_next;
  logic               decision, timeout;

  assign s        = sync_ff[1];
  assign rise     = s & ~s_d;
  assign any_edge = s ^ s_d;

  // NOTE: sequential state always uses non-blocking assignments so every
  // flop samples pre-clock values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= '0;
      s_d     <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[0], sync_in};
      s_d     <= s;
    end
  end

  // Period measurement and edge timeout; all counters saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_cnt <= '0;
      lo_cnt <= '0;
      to_cnt <= '0;
    end else begin
      if (any_edge)              to_cnt <= '0;
      else if (to_cnt != TO_LAST) to_cnt <= to_cnt + 1'b1;

      if (rise) begin
        hi_cnt <= '0;
        lo_cnt <= '0;
      end else if (s) begin
        if (hi_cnt != '1) hi_cnt <= hi_cnt + 1'b1;
      end else begin
        if (lo_cnt != '1) lo_cnt <= lo_cnt + 1'b1;
      end
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    cand_next  = cand;
    agree_next = agree;
    pol_next   = pol;
    // A tie keeps the current candidate, so it counts as agreement.
    decision   = (hi_cnt == lo_cnt) ? cand : (hi_cnt < lo_cnt);
    // An edge in the timeout cycle restarts the counter instead.
    timeout    = !any_edge && (to_cnt == TO_FIRE);

    if (timeout) begin
      state_next = ST_LOST;
      agree_next = '0;
      pol_next   = 1'b0;
    end else if (rise) begin
      if (state == ST_LOST) begin
        // The partial period before the first rising edge is discarded.
        state_next = ST_ACQUIRE;
      end else begin
        if (decision == cand) begin
          if (agree != AGREE_MAX) agree_next = agree + 1'b1;
        end else begin
          cand_next  = decision;
          agree_next = AGREE_W'(1);
        end
        // Lock in ACQUIRE, or switch polarity in LOCKED; locked never drops.
        if (agree_next == AGREE_MAX) begin
          state_next = ST_LOCKED;
          pol_next   = cand_next;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_LOST;
      cand  <= 1'b0;
      agree <= '0;
      pol   <= 1'b0;
    end else begin
      state <= state_next;
      cand  <= cand_next;
      agree <= agree_next;
      pol   <= pol_next;
    end
  end

  // Output register; mode only steers the output, never the detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_out_x <= 1'b1;
    end else begin
      case (mode)
        MODE_AUTO: sync_out_x <= (state == ST_LOCKED) ? (s ^ pol) : s;
        MODE_NEG:  sync_out_x <= s;
        MODE_POS:  sync_out_x <= ~s;
        default:   sync_out_x <= 1'b1;
      endcase
    end
  end

  assign polarity = pol;
  assign present  = (state != ST_LOST);
  assign locked   = (state == ST_LOCKED);

endmodule

// File: rtl/sync_conditioner.sv
// NUM_CH-channel sync front end: one independent sync_channel per input.
// Ports:
//   clk_50mhz_in : system clock
//   reset_x      : asynchronous active-low reset
//   sync_in      : raw sync inputs, asynchronous, either polarity
//   mode         : 2 bits per channel (00 auto, 01 neg, 10 pos, 11 blank)
//   sync_out_x   : registered normalised sync, active low
//   polarity     : locked polarity per channel, 1 = positive-going
//   present      : channel active (not LOST)
//   locked       : polarity locked
module sync_conditioner
  import sync_cond_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 65000,
  parameter int LOCK_CNT    = 4
) (
  input  logic                clk_50mhz_in,
  input  logic                reset_x,
  input  logic [NUM_CH-1:0]   sync_in,
  input  logic [2*NUM_CH-1:0] mode,
  output logic [NUM_CH-1:0]   sync_out_x,
  output logic [NUM_CH-1:0]   polarity,
  output logic [NUM_CH-1:0]   present,
  output logic [NUM_CH-1:0]   locked
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sync_channel #(
      .CNT_W       (CNT_W),
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .LOCK_CNT    (LOCK_CNT)
    ) u_ch (
      .clk        (clk_50mhz_in),
      .rst_n      (reset_x),
      .sync_in    (sync_in[i]),
      .mode       (mode[2*i +: 2]),
      .sync_out_x (sync_out_x[i]),
      .polarity   (polarity[i]),
      .present    (present[i]),
      .locked     (locked[i])
    );
  end

endmodule

// File: tb/tb_sync_conditioner.sv
// Directed bench for sync_conditioner (NUM_CH=2, TIMEOUT_CYC=4096, LOCK_CNT=4).
// Inputs are driven on the falling clock edge, outputs sampled there too.
// Every period starts with its rising edge, so parameter changes made at a
// period boundary give clean measured periods.
module tb_sync_conditioner;

  localparam int PERIOD = 1600;

  logic       clk = 1'b0;
  logic       reset_x;
  logic [1:0] sync_in;
  logic [3:0] mode;
  logic [1:0] sync_out_x, polarity, present, locked;

  int checks   = 0;
  int failures = 0;

  int         cyc = 0;
  logic [1:0] gen_on = '0, man = '0, cmp_en = '0, cmp_inv = '0, mon_lock = '0;
  int         ph [2] = '{0, 0};
  int         hi_len [2] = '{0, 0};
  int         lat_err [2] = '{0, 0};
  int         lock_err [2] = '{0, 0};
  logic [1:0] hist [3] = '{2'b00, 2'b00, 2'b00};

  sync_conditioner #(
    .NUM_CH(2), .CNT_W(16), .TIMEOUT_CYC(4096), .LOCK_CNT(4)
  ) dut (
    .clk_50mhz_in (clk),
    .reset_x      (reset_x),
    .sync_in      (sync_in),
    .mode         (mode),
    .sync_out_x   (sync_out_x),
    .polarity     (polarity),
    .present      (present),
    .locked       (locked)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: score the 3-clock latency relation and lock monitors, then drive.
  task automatic step();
    logic [1:0] nv;
    nv = '0;
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      if (cmp_en[c] && (sync_out_x[c] !== (hist[2][c] ^ cmp_inv[c]))) lat_err[c]++;
      if (mon_lock[c] && (locked[c] !== 1'b1)) lock_err[c]++;
      if (gen_on[c]) begin
        nv[c] = (ph[c] < hi_len[c]);
        ph[c] = (ph[c] == PERIOD - 1) ? 0 : ph[c] + 1;
      end else begin
        nv[c] = man[c];
      end
    end
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = nv;
    sync_in = nv;
    cyc++;
  endtask

  // Runs steps up to and including step index t.
  task automatic run_to(input int t);
    while (cyc <= t) step();
  endtask

  task automatic close_lat(input string tag, input int c);
    check(tag, 32'(lat_err[c]), 32'd0);
    lat_err[c] = 0;
    cmp_en[c]  = 1'b0;
  endtask

  task automatic close_lock(input string tag, input int c);
    check(tag, 32'(lock_err[c]), 32'd0);
    lock_err[c] = 0;
    mon_lock[c] = 1'b0;
  endtask

  initial begin
    // 1. Reset held with toggling inputs.
    reset_x = 1'b0;
    mode    = 4'b0000;
    sync_in = 2'b00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sync_in = 2'(i);
      mode    = (i == 4) ? 4'b1010 : 4'b0000;
    end
    @(negedge clk);
    check("rst_out",  32'(sync_out_x), 32'h3);
    check("rst_pol",  32'(polarity),   32'h0);
    check("rst_pres", 32'(present),    32'h0);
    check("rst_lock", 32'(locked),     32'h0);
    sync_in = 2'b00;
    mode    = 4'b0000;
    reset_x = 1'b1;
    run_to(99);
    check("idle_pres", 32'(present),    32'h0);
    check("idle_out",  32'(sync_out_x), 32'h0);

    // 2. ch0 negative sync (low 190 of 1600), first rising edge at step 100.
    gen_on[0] = 1'b1; ph[0] = 0; hi_len[0] = PERIOD - 190;
    cmp_en[0] = 1'b1; cmp_inv[0] = 1'b0;
    run_to(102);
    check("ch0_pres_before", 32'(present[0]), 32'h0);
    run_to(103);
    check("ch0_pres_after",  32'(present[0]), 32'h1);
    run_to(6502);
    check("ch0_lock_before", 32'(locked[0]),  32'h0);
    run_to(6503);
    check("ch0_lock_after",  32'(locked[0]),  32'h1);
    check("ch0_pol_neg",     32'(polarity[0]), 32'h0);

    // 3. ch1 positive sync (high 190), started on a ch0 period boundary.
    run_to(8099);
    gen_on[1] = 1'b1; ph[1] = 0; hi_len[1] = 190;
    cmp_en[1] = 1'b1; cmp_inv[1] = 1'b0;
    run_to(14502);
    check("ch1_lock_before", 32'(locked[1]),   32'h0);
    run_to(14503);
    check("ch1_lock_after",  32'(locked[1]),   32'h1);
    check("ch1_pol_pos",     32'(polarity[1]), 32'h1);
    check("ch1_pres",        32'(present[1]),  32'h1);
    close_lat("ch1_lat_unlocked", 1);
    cmp_en[1] = 1'b1; cmp_inv[1] = 1'b1; mon_lock[1] = 1'b1;

    // 4. Hysteresis on locked ch0: 3 inverted, 1 normal, then 4 inverted.
    run_to(16099);
    hi_len[0] = 190; mon_lock[0] = 1'b1;
    run_to(20899);
    hi_len[0] = PERIOD - 190;
    run_to(20903);
    check("hyst_pol_after3", 32'(polarity[0]), 32'h0);
    run_to(22499);
    hi_len[0] = 190;
    run_to(22503);
    check("hyst_pol_after_norm", 32'(polarity[0]), 32'h0);
    run_to(28902);
    check("hyst_pol_before4", 32'(polarity[0]), 32'h0);
    run_to(28903);
    check("hyst_pol_after4",  32'(polarity[0]), 32'h1);
    close_lat("ch0_lat_pol0", 0);
    cmp_en[0] = 1'b1; cmp_inv[0] = 1'b1;

    // 5. Loss: last ch0 edge is the falling edge driven at step 29090.
    run_to(29099);
    gen_on[0] = 1'b0; man[0] = 1'b0;
    close_lat("ch0_lat_pol1", 0);
    close_lock("ch0_lock_held", 0);
    run_to(33187);
    check("loss_pres_before", 32'(present[0]), 32'h1);
    run_to(33188);
    check("loss_pres",  32'(present[0]),  32'h0);
    check("loss_lock",  32'(locked[0]),   32'h0);
    check("loss_pol",   32'(polarity[0]), 32'h0);
    check("loss_ch1",   32'({present[1], locked[1], polarity[1]}), 32'h7);
    // Rising edge at 33300, then an edge exactly on the timeout cycle.
    run_to(33299);
    man[0] = 1'b1;
    run_to(33303);
    check("reacq_pres", 32'(present[0]), 32'h1);
    run_to(37394);
    man[0] = 1'b0;
    run_to(37398);
    check("edge_wins_pres", 32'(present[0]), 32'h1);
    run_to(41492);
    check("loss2_pres_before", 32'(present[0]), 32'h1);
    run_to(41493);
    check("loss2_pres", 32'(present[0]), 32'h0);

    // 6. Modes, then reset while ch0 is acquiring.
    run_to(41500);
    check("auto_out0_lost", 32'(sync_out_x[0]), 32'h0);
    mode = 4'b1111;
    close_lat("ch1_lat_locked", 1);
    run_to(41501);
    check("blank_out", 32'(sync_out_x), 32'h3);
    run_to(41519);
    mode = 4'b1110;
    cmp_en[0] = 1'b1; cmp_inv[0] = 1'b1;
    run_to(41599);
    gen_on[0] = 1'b1; ph[0] = 0; hi_len[0] = PERIOD - 190;
    run_to(41603);
    check("acq_pres", 32'(present[0]), 32'h1);
    run_to(43000);
    check("acq_lock",      32'(locked[0]),     32'h0);
    check("blank_out1",    32'(sync_out_x[1]), 32'h1);
    check("blank_ch1_pol", 32'(polarity[1]),   32'h1);
    close_lat("ch0_lat_force_pos", 0);
    close_lock("ch1_lock_held", 1);
    #3;
    reset_x = 1'b0;
    #1;
    check("mid_rst_out",  32'(sync_out_x), 32'h3);
    check("mid_rst_pol",  32'(polarity),   32'h0);
    check("mid_rst_pres", 32'(present),    32'h0);
    check("mid_rst_lock", 32'(locked),     32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
